// File: rtl/pair_queue_scheduler.sv
// pair_queue_scheduler
//   Write-side sequencer for the per-cell pair FIFO. It captures one batch of
//   NSIZE candidate pair records and writes the non-null ones in ascending lane
//   order, at most one per cycle. It stalls while the FIFO is full. Null lanes
//   are skipped without costing a cycle. At the end of each batch it reports
//   completion and the number of records written.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_pairs     NSIZE records, lane i at [PW*i +: PW]; bit PW-1 = null flag
//   in_valid     batch offered by upstream
//   in_ready     scheduler idle and able to capture a batch
//   fifo_din     record being written (null record when not writing)
//   fifo_wr_en   FIFO write strobe
//   fifo_full    FIFO full, same-cycle back-pressure
//   busy         batch in progress
//   batch_done   one-cycle pulse at batch end
//   batch_count  non-null records written in the last batch
module pair_queue_scheduler #(
  parameter int unsigned NSIZE = 14,
  parameter int unsigned PW    = 194,
  parameter int unsigned CW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSIZE*PW-1:0]   in_pairs,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [PW-1:0]         fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  busy,
  output logic                  batch_done,
  output logic [CW-1:0]         batch_count
);

  localparam int unsigned SW = (NSIZE > 1) ? $clog2(NSIZE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     lane_buf [NSIZE];
  logic [NSIZE-1:0]  pending;
  logic [NSIZE-1:0]  pending_in;
  logic [CW-1:0]     count;
  logic [SW-1:0]     sel;
  logic              sel_found;
  logic              last_one;
  logic              capture;

  // Pending mask for a newly offered batch: a lane is pending when its null flag is clear.
  always_comb begin
    pending_in = '0;
    for (int unsigned i = 0; i < NSIZE; i++) begin
      pending_in[i] = ~in_pairs[PW*i + PW - 1];
    end
  end

  // Lowest-index pending lane wins, which gives strictly ascending write order.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NSIZE; i++) begin
      if (pending[i] && !sel_found) begin
        sel       = SW'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign last_one = ((pending & (pending - NSIZE'(1))) == '0);
  assign capture  = (state == IDLE) && in_valid;

  always_comb begin
    state_nxt  = state;
    fifo_wr_en = 1'b0;
    fifo_din   = {1'b1, {(PW-1){1'b0}}};
    unique case (state)
      IDLE: begin
        if (in_valid) state_nxt = (pending_in != '0) ? SCAN : DONE;
      end
      SCAN: begin
        if (!fifo_full) begin
          fifo_wr_en = 1'b1;
          fifo_din   = lane_buf[sel];
          if (last_one) state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign batch_done  = (state == DONE);
  assign batch_count = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pending <= '0;
      count   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        pending <= pending_in;
        count   <= '0;
      end else if (fifo_wr_en) begin
        pending[sel] <= 1'b0;
        count        <= count + CW'(1);
      end
    end
  end

  // Record storage has no reset: it is only read while a pending bit is set,
  // and pending is cleared by reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < NSIZE; i++) begin
        lane_buf[i] <= in_pairs[PW*i +: PW];
      end
    end
  end

endmodule

// File: tb/tb_pair_queue_scheduler.sv
module tb_pair_queue_scheduler;

  localparam int NSIZE = 14;
  localparam int PW    = 194;
  localparam int CW    = 4;

  logic                clk;
  logic                reset;
  logic [NSIZE*PW-1:0] in_pairs;
  logic                in_valid;
  logic                in_ready;
  logic [PW-1:0]       fifo_din;
  logic                fifo_wr_en;
  logic                fifo_full;
  logic                busy;
  logic                batch_done;
  logic [CW-1:0]       batch_count;

  int total = 0;
  int bad   = 0;

  pair_queue_scheduler #(.NSIZE(NSIZE), .PW(PW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_pairs(in_pairs), .in_valid(in_valid),
    .in_ready(in_ready), .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en),
    .fifo_full(fifo_full), .busy(busy), .batch_done(batch_done),
    .batch_count(batch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] null_mask;
    int          stall_start;
    int          stall_len;
    int          exp_k;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];

  localparam logic [PW-1:0] NULL_REC = {1'b1, {(PW-1){1'b0}}};

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rec(input int lane, input bit nul);
    logic [PW-1:0] r;
    r = '0;
    r[PW-1] = nul;
    r[7:0]  = 8'(lane);
    return r;
  endfunction

  function automatic logic [NSIZE*PW-1:0] mk(input logic [13:0] nm);
    logic [NSIZE*PW-1:0] p;
    p = '0;
    for (int i = 0; i < NSIZE; i++) p[PW*i +: PW] = rec(i, nm[i]);
    return p;
  endfunction

  // Offer one batch for a single cycle, then follow it to completion.
  task automatic run_batch(input vec_t v);
    logic [PW-1:0] expq [$];
    int widx;
    bit seen;
    for (int i = 0; i < NSIZE; i++)
      if (!v.null_mask[i]) expq.push_back(rec(i, 1'b0));
    @(negedge clk);
    in_pairs  = mk(v.null_mask);
    in_valid  = 1'b1;
    fifo_full = 1'b0;
    #1 chk("ready_before_capture", in_ready, 1);
    widx = 0;
    seen = 0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      fifo_full = (n >= v.stall_start) && (n < v.stall_start + v.stall_len);
      #1;
      chk("wr_while_full", fifo_wr_en & fifo_full, 0);
      chk("ready_low_busy", {in_ready, busy}, 2'b01);
      if (fifo_wr_en) begin
        if (widx < expq.size()) chk("write_data", fifo_din, expq[widx]);
        else chk("extra_write", 1, 0);
        widx++;
      end else begin
        chk("idle_din_null", fifo_din, NULL_REC);
      end
      if (batch_done) begin
        seen = 1;
        chk("done_cycle", n, v.exp_done);
        chk("batch_count", batch_count, v.exp_k);
        chk("write_total", widx, v.exp_k);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    fifo_full = 1'b0;
    #1;
    chk("ready_after_done", {in_ready, busy, batch_done}, 3'b100);
  endtask

  initial begin
    int wc;
    bit seen;

    // null_mask, stall_start, stall_len, exp_k, exp_done
    vecs[0] = '{14'h3FFF, 0, 0,  0,  1};   // all null
    vecs[1] = '{14'h1FDB, 0, 0,  3,  4};   // lanes 2,5,13
    vecs[2] = '{14'h0000, 3, 3, 14, 18};   // full batch, full during T+3..T+5
    vecs[3] = '{14'h3FFE, 0, 0,  1,  2};   // lane 0 only
    vecs[4] = '{14'h1FFF, 1, 2,  1,  4};   // lane 13 only, stalled first 2 cycles
    vecs[5] = '{14'h2AAA, 0, 0,  7,  8};   // even lanes

    reset    = 1'b0;
    in_valid = 1'b0;
    fifo_full = 1'b0;
    in_pairs = '0;

    // Reset / idle.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;   // must be ignored under reset
      in_pairs = mk(14'h0000);
      #1;
      chk("rst_outputs", {in_ready, fifo_wr_en, busy, batch_done, batch_count}, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
      chk("rst_din", fifo_din, NULL_REC);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("post_rst_outputs", {in_ready, fifo_wr_en, busy, batch_count}, {1'b1, 1'b0, 1'b0, 4'd0});
    chk("post_rst_null_flag", fifo_din[PW-1], 1);

    for (int t = 0; t < 6; t++) run_batch(vecs[t]);

    // Reset mid-batch after the sixth write.
    @(negedge clk);
    in_pairs = mk(14'h0000);
    in_valid = 1'b1;
    wc = 0;
    for (int n = 1; n <= 20 && wc < 6; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (fifo_wr_en) begin
        chk("mid_write_data", fifo_din, rec(wc, 1'b0));
        wc++;
      end
    end
    chk("mid_six_writes", wc, 6);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_outputs", {in_ready, fifo_wr_en, busy, batch_done, batch_count}, {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    chk("mid_rst_din", fifo_din, NULL_REC);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 chk("mid_no_done", {batch_done, fifo_wr_en}, 2'b00);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_ready_release", {in_ready, batch_done}, 2'b10);
    run_batch(vecs[1]);

    // Upstream holds in_valid through a k=4 batch.
    @(negedge clk);
    in_pairs = mk(14'h3FF0);
    in_valid = 1'b1;
    #1 chk("hold_ready0", in_ready, 1);
    wc = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      #1;
      chk("hold_not_ready", in_ready, 0);
      if (fifo_wr_en) begin
        chk("hold_write_data", fifo_din, rec(wc, 1'b0));
        wc++;
      end
      if (n == 5) chk("hold_done_count", {batch_done, batch_count}, {1'b1, 4'd4});
      else        chk("hold_no_done", batch_done, 0);
    end
    chk("hold_first_writes", wc, 4);
    @(negedge clk);
    #1 chk("hold_ready_t6", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("hold_second_capture", {busy, fifo_wr_en}, 2'b11);
    chk("hold_second_lane0", fifo_din, rec(0, 1'b0));
    wc = 1;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (fifo_wr_en) wc++;
      if (batch_done) begin
        seen = 1;
        chk("hold_second_count", batch_count, 4);
        chk("hold_second_writes", wc, 4);
      end
    end
    if (!seen) chk("hold_second_timeout", 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
